// File: rtl/math_pkg.sv
// Shared definitions for the math datapath.
//   add_seq_state_t : FSM states of the multi-cycle adder
//   WIDTH_DEF       : default total operand width
//   SLICE_DEF       : default bits added per clock
package math_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } add_seq_state_t;

  localparam int WIDTH_DEF = 256;
  localparam int SLICE_DEF = 64;

endpackage : math_pkg

// File: rtl/add_64bit.sv
// Combinational 64-bit carry-lookahead adder.
// Two levels: 4-bit groups produce group generate/propagate, the group
// carries are resolved across the 16 groups, then each group expands its
// carry-in into per-bit carries.
//   din1, din2 : 64-bit addends
//   cin        : carry in
//   dout       : 64-bit sum
//   cout       : carry out of bit 63
//   c_msb      : carry into bit 63 (for signed overflow detection)
module add_64bit (
  input  logic [63:0] din1,
  input  logic [63:0] din2,
  input  logic        cin,
  output logic [63:0] dout,
  output logic        cout,
  output logic        c_msb
);

  logic [63:0] g;
  logic [63:0] p;
  logic [64:0] c;
  logic [15:0] gg;
  logic [15:0] gp;
  logic [16:0] gc;

  assign g = din1 & din2;
  assign p = din1 ^ din2;

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;

    // Group generate / propagate over each 4-bit nibble.
    for (int k = 0; k < 16; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end

    // Carry into each group.
    gc[0] = cin;
    for (int k = 0; k < 16; k++) begin
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end

    // Expand each group carry into its four bit carries.
    for (int k = 0; k < 16; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
    c[64] = gc[16];
  end

  assign dout  = p ^ c[63:0];
  assign cout  = c[64];
  assign c_msb = c[63];

endmodule : add_64bit

// File: rtl/add_256bit_seq.sv
// Multi-cycle WIDTH-bit adder: din1 + din2 + cin, one SLICE-bit slice per
// clock, LSB slice first, carry held in a register between slices.
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   in_valid   : operands valid         in_ready  : idle, accepts operands
//   din1, din2 : addends                cin       : carry in
//   out_valid  : result valid (held)    out_ready : downstream accepts
//   dout       : sum modulo 2^WIDTH     cout      : unsigned carry out
//   ovf        : two's-complement overflow
module add_256bit_seq
  import math_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             cout,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  add_seq_state_t state;
  add_seq_state_t next_state;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [IDXW-1:0]  idx;

  logic [SLICE-1:0] s_sum;
  logic             s_cout;
  logic             s_msb;

  logic accept;
  logic last;

  // Handshake flags come straight from the state register.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (idx == LAST_IDX);

  // Single slice adder, fed by whichever slice idx selects.
  add_64bit u_slice (
    .din1  (op_a[idx*SLICE +: SLICE]),
    .din2  (op_b[idx*SLICE +: SLICE]),
    .cin   (carry),
    .dout  (s_sum),
    .cout  (s_cout),
    .c_msb (s_msb)
  );

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept)    next_state = RUN;
      RUN:     if (last)      next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default:                next_state = IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking <= so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Visible results are reset; a reset mid-operation leaves dout at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (state == RUN) begin
      dout[idx*SLICE +: SLICE] <= s_sum;
      if (last) begin
        cout <= s_cout;
        // Overflow: carry into the MSB differs from carry out of it.
        ovf  <= s_cout ^ s_msb;
      end
    end
  end

  // NOTE: operand, carry and index registers are deliberately not reset;
  // they are always loaded on acceptance before being read.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      if (accept) begin
        op_a  <= din1;
        op_b  <= din2;
        carry <= cin;
        idx   <= '0;
      end
    end else if (state == RUN) begin
      carry <= s_cout;
      // Hold at the last slice rather than wrap; RUN exits there anyway.
      if (!last) idx <= idx + 1'b1;
    end
  end

endmodule : add_256bit_seq
